// File: rtl/dfs_pkg.sv
// dfs_pkg: FSM state encoding and saturating adder shared by the DFS search engine
package dfs_pkg;
   typedef enum logic [2:0] {S_IDLE, S_POP, S_FETCH, S_EVAL, S_PUSH, S_DONE} state_t;
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
      logic [32:0] s;
      logic [32:0] lim;
      s = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (s > lim) ? lim[31:0] : s[31:0];
   endfunction
endpackage

// File: rtl/dfs_stack.sv
// dfs_stack: synchronous LIFO; clr empties it and may coincide with a push into slot 0
module dfs_stack #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH) + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] sp, wp;
   assign wp    = clr ? '0 : sp;
   assign full  = sp == PW'(DEPTH);
   assign empty = sp == '0;
   assign dout  = mem[(PW-1)'(sp - PW'(1))];
   always_ff @(posedge clk)
      if (!rst_n) sp <= '0;
      else sp <= wp + PW'(push) - PW'(pop);
   always_ff @(posedge clk)
      if (push && (clr || !full)) mem[(PW-1)'(wp)] <= din;
endmodule

// File: rtl/dfs_search_engine.sv
// dfs_search_engine: depth-first tree walker over external node memory with best-leaf cost tracking
module dfs_search_engine import dfs_pkg::*; #(
   parameter int AW        = 8,
   parameter int WW        = 8,
   parameter int MAX_CHILD = 4,
   parameter int DEPTH     = 16,
   parameter int PRUNE     = 1,
   localparam int CW       = $clog2(MAX_CHILD + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          done_ack,
   input  logic          mode_max,
   input  logic [AW-1:0] root_addr,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [WW-1:0] mem_weight,
   input  logic [CW-1:0] mem_nchild,
   input  logic [AW-1:0] mem_child_base,
   output logic          busy,
   output logic          done,
   output logic          best_valid,
   output logic [WW-1:0] best_cost,
   output logic [AW-1:0] best_leaf,
   output logic [15:0]   leaf_count,
   output logic [15:0]   nodes_visited,
   output logic          err_overflow,
   output logic          err_fanout,
   output logic          err_abort
);
   typedef struct packed {logic [AW-1:0] addr; logic [WW-1:0] acc;} entry_t;
   state_t        state, state_n;
   entry_t        din, dout;
   logic          push, pop, clr, full, empty, active, better, prune, mode_r;
   logic [AW-1:0] cur_addr, base;
   logic [WW-1:0] cur_acc, wt, acc_n;
   logic [CW-1:0] nch, nch_eff, idx;
   assign active   = state inside {S_POP, S_FETCH, S_EVAL, S_PUSH};
   assign busy     = active;
   assign done     = state == S_DONE;
   assign mem_req  = state == S_FETCH;
   assign mem_addr = cur_addr;
   assign acc_n    = WW'(sat_add(32'(cur_acc), 32'(wt), WW));
   assign nch_eff  = (nch > CW'(MAX_CHILD)) ? CW'(MAX_CHILD) : nch;
   assign better   = !best_valid || (mode_r ? acc_n > best_cost : acc_n < best_cost);
   assign prune    = PRUNE != 0 && !mode_r && best_valid && acc_n >= best_cost;
   dfs_stack #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_stack (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
      .din(din), .dout(dout), .full(full), .empty(empty)
   );
   always_ff @(posedge clk)
      if (!rst_n) state <= S_IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      clr     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      din     = '{addr: base + AW'(idx), acc: cur_acc};
      if (active && abort) state_n = S_DONE;
      else case (state)
         S_IDLE: begin
            clr     = start;
            push    = start;
            din     = '{addr: root_addr, acc: '0};
            state_n = start ? S_POP : S_IDLE;
         end
         S_POP: begin
            pop     = !empty;
            state_n = empty ? S_DONE : S_FETCH;
         end
         S_FETCH: state_n = mem_ack ? S_EVAL : S_FETCH;
         S_EVAL:  state_n = (nch_eff == '0 || prune) ? S_POP : S_PUSH;
         S_PUSH: begin
            push    = !full;
            state_n = full ? S_DONE : (idx == '0 ? S_POP : S_PUSH);
         end
         default: state_n = done_ack ? S_IDLE : S_DONE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_r        <= 1'b0;
         cur_addr      <= '0;
         cur_acc       <= '0;
         wt            <= '0;
         nch           <= '0;
         base          <= '0;
         idx           <= '0;
         best_valid    <= 1'b0;
         best_cost     <= '0;
         best_leaf     <= '0;
         leaf_count    <= '0;
         nodes_visited <= '0;
         err_overflow  <= 1'b0;
         err_fanout    <= 1'b0;
         err_abort     <= 1'b0;
      end else if (active && abort) err_abort <= 1'b1;
      else case (state)
         S_IDLE: if (start) begin
            mode_r        <= mode_max;
            best_valid    <= 1'b0;
            best_cost     <= '0;
            best_leaf     <= '0;
            leaf_count    <= '0;
            nodes_visited <= '0;
            err_overflow  <= 1'b0;
            err_fanout    <= 1'b0;
            err_abort     <= 1'b0;
         end
         S_POP: if (!empty) begin
            cur_addr <= dout.addr;
            cur_acc  <= dout.acc;
         end
         S_FETCH: if (mem_ack) begin
            wt   <= mem_weight;
            nch  <= mem_nchild;
            base <= mem_child_base;
         end
         S_EVAL: begin
            nodes_visited <= nodes_visited + 16'd1;
            cur_acc       <= acc_n;
            idx           <= nch_eff - CW'(1);
            if (nch > CW'(MAX_CHILD)) err_fanout <= 1'b1;
            if (nch_eff == '0) begin
               leaf_count <= leaf_count + 16'd1;
               if (better) begin
                  best_valid <= 1'b1;
                  best_cost  <= acc_n;
                  best_leaf  <= cur_addr;
               end
            end
         end
         S_PUSH: if (full) err_overflow <= 1'b1;
                 else idx <= idx - CW'(1);
         default: ;
      endcase
   end
endmodule

// File: tb/tb_dfs_search_engine.sv
// tb_dfs_search_engine: directed and random tree searches checked against a queue-based DFS model
module tb_dfs_search_engine;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 0, abort = 0, done_ack = 0, mode_max = 0;
   logic [7:0] root_addr = 0;
   logic mem_req, mem_ack = 0, busy, done, best_valid, err_overflow, err_fanout, err_abort;
   logic [7:0] mem_addr, mem_weight = 0, mem_child_base = 0, best_cost, best_leaf;
   logic [2:0] mem_nchild = 0;
   logic [15:0] leaf_count, nodes_visited;
   logic start2 = 0, done_ack2 = 0, mem_req2, mem_ack2 = 0, busy2, done2, best_valid2;
   logic err_overflow2, err_fanout2, err_abort2;
   logic [7:0] mem_addr2, mem_weight2 = 0, mem_child_base2 = 0, best_cost2, best_leaf2;
   logic [2:0] mem_nchild2 = 0;
   logic [15:0] leaf_count2, nodes_visited2;
   logic [7:0] w_mem [256];
   logic [2:0] n_mem [256];
   logic [7:0] b_mem [256];
   int n_cmp = 0, n_err = 0;
   int ack_dly = 0, wait_cnt = 0, stab_err = 0;
   logic [7:0] held;
   int fetched[$];
   int m_cost, m_leaf, m_leaves, m_nodes;
   bit m_valid, m_fan;
   int m_order[$];

   always #5 clk = ~clk;

   dfs_search_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .done_ack(done_ack),
      .mode_max(mode_max), .root_addr(root_addr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_weight(mem_weight), .mem_nchild(mem_nchild),
      .mem_child_base(mem_child_base), .busy(busy), .done(done), .best_valid(best_valid),
      .best_cost(best_cost), .best_leaf(best_leaf), .leaf_count(leaf_count),
      .nodes_visited(nodes_visited), .err_overflow(err_overflow), .err_fanout(err_fanout),
      .err_abort(err_abort)
   );
   dfs_search_engine #(.DEPTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .done_ack(done_ack2),
      .mode_max(1'b0), .root_addr(8'd50), .mem_req(mem_req2), .mem_addr(mem_addr2),
      .mem_ack(mem_ack2), .mem_weight(mem_weight2), .mem_nchild(mem_nchild2),
      .mem_child_base(mem_child_base2), .busy(busy2), .done(done2), .best_valid(best_valid2),
      .best_cost(best_cost2), .best_leaf(best_leaf2), .leaf_count(leaf_count2),
      .nodes_visited(nodes_visited2), .err_overflow(err_overflow2), .err_fanout(err_fanout2),
      .err_abort(err_abort2)
   );

   // node memory with a programmable ack latency; also watches address stability while waiting
   always @(negedge clk) begin
      if (mem_req) begin
         if (wait_cnt == 0) held = mem_addr;
         else if (mem_addr !== held) stab_err++;
         if (wait_cnt >= ack_dly) begin
            mem_ack = 1'b1;
            mem_weight = w_mem[mem_addr];
            mem_nchild = n_mem[mem_addr];
            mem_child_base = b_mem[mem_addr];
            fetched.push_back(int'(mem_addr));
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   always @(negedge clk) begin
      mem_ack2 = mem_req2;
      mem_weight2 = w_mem[mem_addr2];
      mem_nchild2 = n_mem[mem_addr2];
      mem_child_base2 = b_mem[mem_addr2];
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 256; a++) begin
         w_mem[a] = 0; n_mem[a] = 0; b_mem[a] = 0;
      end
   endtask

   task automatic node(input int a, input int w, input int n, input int b);
      w_mem[a] = 8'(w); n_mem[a] = 3'(n); b_mem[a] = 8'(b);
   endtask

   // reference: explicit-stack DFS over the node arrays, following the search rules directly
   task automatic model(input int root, input bit mx);
      int sa[$], sc[$];
      int a, c, n;
      m_valid = 0; m_cost = 0; m_leaf = 0; m_leaves = 0; m_nodes = 0; m_fan = 0;
      m_order.delete();
      sa.push_back(root); sc.push_back(0);
      while (sa.size() > 0) begin
         a = sa.pop_back(); c = sc.pop_back();
         m_nodes++; m_order.push_back(a);
         c = c + int'(w_mem[a]);
         if (c > 255) c = 255;
         n = int'(n_mem[a]);
         if (n > 4) begin m_fan = 1; n = 4; end
         if (n == 0) begin
            m_leaves++;
            if (!m_valid || (mx ? c > m_cost : c < m_cost)) begin
               m_valid = 1; m_cost = c; m_leaf = a;
            end
         end else if (mx || !m_valid || c < m_cost)
            for (int i = n - 1; i >= 0; i--) begin
               sa.push_back((int'(b_mem[a]) + i) % 256);
               sc.push_back(c);
            end
      end
   endtask

   task automatic gen_tree(output int root);
      int q[$];
      int nxt, cnt, a, n;
      clear_mem();
      root = $urandom_range(0, 255);
      nxt = root + 1; cnt = 1;
      q.push_back(root);
      while (q.size() > 0) begin
         a = q.pop_front();
         n = (cnt < 10) ? $urandom_range(0, 3) : 0;
         node(a, ($urandom_range(0, 3) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 40), n, nxt % 256);
         for (int i = 0; i < n; i++) q.push_back((nxt + i) % 256);
         nxt += n; cnt += n;
      end
   endtask

   task automatic search(input string nm, input int root, input bit mx, input int dly);
      int cyc, diff;
      model(root, mx);
      ack_dly = dly; fetched.delete(); stab_err = 0;
      @(negedge clk); root_addr = 8'(root); mode_max = mx; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
      chk({nm, ".done"}, done, 1);
      chk({nm, ".best_valid"}, best_valid, m_valid);
      chk({nm, ".best_cost"}, best_cost, m_cost);
      chk({nm, ".best_leaf"}, best_leaf, m_leaf);
      chk({nm, ".leaf_count"}, leaf_count, m_leaves);
      chk({nm, ".nodes_visited"}, nodes_visited, m_nodes);
      chk({nm, ".err_fanout"}, err_fanout, m_fan);
      chk({nm, ".err_overflow"}, err_overflow, 0);
      chk({nm, ".err_abort"}, err_abort, 0);
      chk({nm, ".addr_stable"}, stab_err, 0);
      diff = (fetched.size() == m_order.size()) ? -1 : -2;
      if (diff == -1)
         for (int i = 0; i < m_order.size(); i++)
            if (diff == -1 && fetched[i] != m_order[i]) diff = i;
      chk({nm, ".fetch_order_first_diff"}, diff, -1);
      @(negedge clk); done_ack = 1'b1;
      @(negedge clk); done_ack = 1'b0;
      chk({nm, ".back_to_idle"}, {busy, done}, 0);
   endtask

   initial begin
      int root, cyc;
      clear_mem();
      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.mem_req", mem_req, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.best", {best_valid, best_cost, best_leaf}, 0);
      chk("rst.counts", {leaf_count, nodes_visited}, 0);
      chk("rst.errs", {err_overflow, err_fanout, err_abort}, 0);
      rst_n = 1'b1;

      node(5, 7, 0, 0);
      search("single_leaf", 5, 0, 0);
      chk("single_leaf.cost_const", best_cost, 7);
      chk("single_leaf.leaf_const", best_leaf, 5);

      clear_mem();
      node(0, 0, 3, 1); node(1, 3, 0, 0); node(2, 1, 0, 0); node(3, 2, 0, 0);
      search("tree_min", 0, 0, 0);
      chk("tree_min.leaf_const", best_leaf, 2);
      chk("tree_min.cost_const", best_cost, 1);
      search("tree_max", 0, 1, 1);
      chk("tree_max.leaf_const", best_leaf, 1);
      chk("tree_max.cost_const", best_cost, 3);
      search("tree_delay3", 0, 0, 3);

      clear_mem();
      node(0, 0, 2, 1); node(1, 5, 0, 0); node(2, 5, 0, 0);
      search("tie_min", 0, 0, 0);
      chk("tie_min.first_leaf", best_leaf, 1);
      search("tie_max", 0, 1, 0);
      chk("tie_max.first_leaf", best_leaf, 1);

      clear_mem();
      node(0, 0, 2, 1); node(1, 1, 0, 0); node(2, 5, 2, 3); node(3, 0, 0, 0); node(4, 0, 0, 0);
      search("prune_min", 0, 0, 0);
      chk("prune_min.nodes_const", nodes_visited, 3);
      search("noprune_max", 0, 1, 0);
      chk("noprune_max.nodes_const", nodes_visited, 5);

      clear_mem();
      node(20, 1, 7, 10);
      for (int i = 10; i < 14; i++) node(i, i, 0, 0);
      search("fanout", 20, 0, 0);
      chk("fanout.flag_const", err_fanout, 1);
      chk("fanout.nodes_const", nodes_visited, 5);

      clear_mem();
      node(0, 200, 1, 1); node(1, 100, 0, 0);
      search("saturate", 0, 1, 2);
      chk("saturate.cost_const", best_cost, 255);

      clear_mem();
      node(50, 1, 4, 60);
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("overflow.done", done2, 1);
      chk("overflow.flag", err_overflow2, 1);
      chk("overflow.nodes", nodes_visited2, 1);
      @(negedge clk); done_ack2 = 1'b1;
      @(negedge clk); done_ack2 = 1'b0;
      chk("overflow.idle", {busy2, done2}, 0);

      node(0, 0, 3, 1); node(1, 3, 0, 0); node(2, 1, 0, 0); node(3, 2, 0, 0);
      ack_dly = 1000;
      @(negedge clk); root_addr = 0; mode_max = 0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!mem_req && cyc < 20) begin @(negedge clk); cyc++; end
      chk("abort.reached_fetch", mem_req, 1);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort.done", done, 1);
      chk("abort.flag", err_abort, 1);
      chk("abort.mem_req", mem_req, 0);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("abort.start_ignored", {busy, done}, 1);
      done_ack = 1'b1;
      @(negedge clk); done_ack = 1'b0;
      chk("abort.idle", {busy, done, err_abort}, 1);

      ack_dly = 2;
      @(negedge clk); root_addr = 0; mode_max = 1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("midreset.state", {busy, done, mem_req}, 0);
      chk("midreset.results", {best_valid, best_cost, leaf_count, nodes_visited}, 0);
      chk("midreset.errs", {err_overflow, err_fanout, err_abort}, 0);

      for (int t = 0; t < 30; t++) begin
         gen_tree(root);
         search($sformatf("rand%0d", t), root, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
